// File: rtl/fpnew_divsqrt_issue_queue_if.sv
// Handshake and payload bundle between the DIVSQRT operation group and its issue queue.
// The master side issues operations and consumes the head entry; the slave side is the queue.
interface fpnew_divsqrt_issue_queue_if #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned NUM_FORMATS = 5,
    parameter int unsigned AuxWidth    = 1,
    parameter int unsigned Depth       = 2
);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [1:0][WIDTH-1:0]       operands_i;
    logic [NUM_FORMATS-1:0][1:0] is_boxed_i;
    logic [2:0]                  rnd_mode_i;
    logic [3:0]                  op_i;
    logic [2:0]                  dst_fmt_i;
    logic                        tag_i;
    logic [AuxWidth-1:0]         aux_i;
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic                        flush_i;

    logic [1:0][WIDTH-1:0]       operands_o;
    logic [2:0]                  rnd_mode_o;
    logic [3:0]                  op_o;
    logic [2:0]                  dst_fmt_o;
    logic                        tag_o;
    logic [AuxWidth-1:0]         aux_o;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic [CntW-1:0]             usage_o;
    logic                        busy_o;

    modport master (
        output operands_i, is_boxed_i, rnd_mode_i, op_i, dst_fmt_i, tag_i, aux_i,
        output in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, operands_o, rnd_mode_o, op_o, dst_fmt_o, tag_o, aux_o,
        input  out_valid_o, usage_o, busy_o
    );

    modport slave (
        input  operands_i, is_boxed_i, rnd_mode_i, op_i, dst_fmt_i, tag_i, aux_i,
        input  in_valid_i, flush_i, out_ready_i,
        output in_ready_o, operands_o, rnd_mode_o, op_o, dst_fmt_o, tag_o, aux_o,
        output out_valid_o, usage_o, busy_o
    );
endinterface

// File: rtl/fpnew_divsqrt_issue_queue.sv
// Circular FIFO in front of the iterative divide/sqrt unit; improperly NaN-boxed
// operands are replaced by the destination format's canonical NaN before storage.
module fpnew_divsqrt_issue_queue #(
    parameter int unsigned Depth       = 2,
    parameter int unsigned AuxWidth    = 1,
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned NUM_FORMATS = 5
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    fpnew_divsqrt_issue_queue_if.slave io
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    function automatic int unsigned fmt_width(input logic [2:0] fmt);
        int unsigned w;
        case (fmt)
            3'd0:    w = 32;
            3'd1:    w = 64;
            3'd2:    w = 16;
            3'd3:    w = 8;
            3'd4:    w = 16;
            default: w = WIDTH;
        endcase
        return w;
    endfunction

    function automatic logic [63:0] fmt_canon(input logic [2:0] fmt);
        logic [63:0] c;
        case (fmt)
            3'd0:    c = 64'h0000_0000_7FC0_0000;
            3'd1:    c = 64'h7FF8_0000_0000_0000;
            3'd2:    c = 64'h0000_0000_0000_7E00;
            3'd3:    c = 64'h0000_0000_0000_007E;
            3'd4:    c = 64'h0000_0000_0000_7FC0;
            default: c = '0;
        endcase
        return c;
    endfunction

    logic [1:0][WIDTH-1:0] r_ops  [Depth];
    logic [2:0]            r_rnd  [Depth];
    logic [3:0]            r_op   [Depth];
    logic [2:0]            r_fmt  [Depth];
    logic                  r_tag  [Depth];
    logic [AuxWidth-1:0]   r_aux  [Depth];

    logic [PtrW-1:0] r_wptr, r_rptr;
    logic [CntW-1:0] r_cnt;

    logic [1:0][WIDTH-1:0] w_ops;
    logic [1:0]            w_boxed;
    int unsigned           w_fw;
    logic [63:0]           w_canon;
    logic                  w_in_ready, w_out_valid, w_push, w_pop;
    logic [PtrW-1:0]       w_wptr_nxt, w_rptr_nxt;

    // Operands narrower than WIDTH lacking a valid box become all-ones above the canonical NaN.
    always_comb begin
        w_fw    = fmt_width(io.dst_fmt_i);
        w_canon = fmt_canon(io.dst_fmt_i);
        w_boxed = 2'b11;
        if (32'(io.dst_fmt_i) < NUM_FORMATS) w_boxed = io.is_boxed_i[io.dst_fmt_i];
        for (int unsigned k = 0; k < 2; k++) begin
            w_ops[k] = io.operands_i[k];
            if ((w_fw < WIDTH) && !w_boxed[k]) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_ops[k][i] = (i < w_fw) ? w_canon[i[5:0]] : 1'b1;
                end
            end
        end
    end

    assign w_in_ready  = (r_cnt != FullCnt);
    assign w_out_valid = (r_cnt != '0) & ~io.flush_i;
    assign w_push      = io.in_valid_i & w_in_ready & ~io.flush_i;
    assign w_pop       = w_out_valid & io.out_ready_i;
    assign w_wptr_nxt  = (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt  = (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_ops[r_wptr] <= w_ops;
            r_rnd[r_wptr] <= io.rnd_mode_i;
            r_op[r_wptr]  <= io.op_i;
            r_fmt[r_wptr] <= io.dst_fmt_i;
            r_tag[r_wptr] <= io.tag_i;
            r_aux[r_wptr] <= io.aux_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (io.flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= w_wptr_nxt;
            if (w_pop)  r_rptr <= w_rptr_nxt;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    assign io.in_ready_o  = w_in_ready;
    assign io.out_valid_o = w_out_valid;
    assign io.operands_o  = r_ops[r_rptr];
    assign io.rnd_mode_o  = r_rnd[r_rptr];
    assign io.op_o        = r_op[r_rptr];
    assign io.dst_fmt_o   = r_fmt[r_rptr];
    assign io.tag_o       = r_tag[r_rptr];
    assign io.aux_o       = r_aux[r_rptr];
    assign io.usage_o     = r_cnt;
    assign io.busy_o      = (r_cnt != '0);
endmodule

// File: tb/tb_fpnew_divsqrt_issue_queue.sv
// Randomized bench for the divsqrt issue queue against a queue-based reference model.
module tb_fpnew_divsqrt_issue_queue;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned W     = 64;
    localparam int unsigned NF    = 5;
    localparam int unsigned AW    = 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  rnd;
        logic [3:0]  op;
        logic [2:0]  fmt;
        logic        tag;
        logic        aux;
        logic [9:0]  boxed;
    } stim_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  rnd;
        logic [3:0]  op;
        logic [2:0]  fmt;
        logic        tag;
        logic        aux;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpnew_divsqrt_issue_queue_if #(.WIDTH(W), .NUM_FORMATS(NF), .AuxWidth(AW), .Depth(DEPTH)) bus ();

    fpnew_divsqrt_issue_queue #(.Depth(DEPTH), .AuxWidth(AW), .WIDTH(W), .NUM_FORMATS(NF)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .io    (bus)
    );

    entry_t mq[$];
    stim_t  cur;
    int     checks   = 0;
    int     failures = 0;

    function automatic entry_t expect_of(input stim_t s);
        entry_t      e;
        int          fw;
        logic [63:0] canon;
        logic [1:0]  bx;
        case (s.fmt)
            3'd0:    begin fw = 32; canon = 64'h7FC00000;         end
            3'd2:    begin fw = 16; canon = 64'h7E00;             end
            3'd3:    begin fw = 8;  canon = 64'h7E;               end
            3'd4:    begin fw = 16; canon = 64'h7FC0;             end
            default: begin fw = 64; canon = 64'h7FF8000000000000; end
        endcase
        bx    = s.boxed[2*int'(s.fmt) +: 2];
        e.a   = (fw < 64 && !bx[0]) ? ((~64'd0 << fw) | canon) : s.a;
        e.b   = (fw < 64 && !bx[1]) ? ((~64'd0 << fw) | canon) : s.b;
        e.rnd = s.rnd;
        e.op  = s.op;
        e.fmt = s.fmt;
        e.tag = s.tag;
        e.aux = s.aux;
        return e;
    endfunction

    function automatic entry_t observe();
        entry_t e;
        e.a   = bus.operands_o[0];
        e.b   = bus.operands_o[1];
        e.rnd = bus.rnd_mode_o;
        e.op  = bus.op_o;
        e.fmt = bus.dst_fmt_o;
        e.tag = bus.tag_o;
        e.aux = bus.aux_o;
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.a     = {$urandom, $urandom};
        s.b     = {$urandom, $urandom};
        s.rnd   = 3'($urandom_range(0, 4));
        s.op    = 4'($urandom_range(4, 5));
        s.fmt   = 3'($urandom_range(0, 4));
        s.tag   = 1'($urandom);
        s.aux   = 1'($urandom);
        s.boxed = 10'($urandom);
        return s;
    endfunction

    task automatic drive(input stim_t s, input logic v);
        cur              = s;
        bus.operands_i[0] = s.a;
        bus.operands_i[1] = s.b;
        bus.rnd_mode_i   = s.rnd;
        bus.op_i         = s.op;
        bus.dst_fmt_i    = s.fmt;
        bus.tag_i        = s.tag;
        bus.aux_i        = s.aux;
        bus.is_boxed_i   = s.boxed;
        bus.in_valid_i   = v;
    endtask

    // Advance one clock, updating the reference queue from the inputs as driven.
    task automatic advance();
        bit push, pop;
        push = bus.in_valid_i && (mq.size() != DEPTH) && !bus.flush_i;
        pop  = (mq.size() != 0) && !bus.flush_i && bus.out_ready_i;
        @(posedge clk);
        if (bus.flush_i) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(expect_of(cur));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.out_ready_i = 1'b0;
        drive(rand_stim(), 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
        checks++; if (bus.usage_o !== '0) begin failures++; $display("FAIL reset_usage got=%0d exp=0", bus.usage_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        @(negedge clk);
    endtask

    task automatic test_single_push();
        stim_t  s;
        entry_t g;
        s       = '0;
        s.a     = 64'h4000000000000000;
        s.b     = 64'h3FF0000000000000;
        s.op    = 4'd4;
        s.fmt   = 3'd1;
        s.tag   = 1'b1;
        s.boxed = '1;
        bus.out_ready_i = 1'b0;
        drive(s, 1'b1);
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", bus.out_valid_o); end
        advance();
        idle();
        #1;
        g = observe();
        checks++; if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.out_valid_o); end
        checks++; if (g.a !== 64'h4000000000000000 || g.b !== 64'h3FF0000000000000 || g.op !== 4'd4 || g.fmt !== 3'd1 || g.tag !== 1'b1)
            begin failures++; $display("FAIL single_fields got=%h exp a=4000000000000000 b=3ff0000000000000 op=4 fmt=1 tag=1", g); end
        checks++; if (bus.usage_o !== CW'(1)) begin failures++; $display("FAIL single_usage got=%0d exp=1", bus.usage_o); end
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy_o); end
        bus.out_ready_i = 1'b1;
        advance();
        bus.out_ready_i = 1'b0;
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", bus.out_valid_o); end
    endtask

    task automatic test_boxing();
        logic [2:0]  fmts  [5];
        logic [63:0] exp_a [5];
        stim_t       s;
        entry_t      g;
        fmts  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd1};
        exp_a = '{64'hFFFFFFFF7FC00000, 64'hFFFFFFFFFFFF7E00, 64'hFFFFFFFFFFFFFF7E,
                  64'hFFFFFFFFFFFF7FC0, 64'h0000000040490FDB};
        for (int i = 0; i < 5; i++) begin
            s       = rand_stim();
            s.a     = 64'h0000000040490FDB;
            s.op    = 4'd5;
            s.fmt   = fmts[i];
            s.boxed = '1;
            s.boxed[2*int'(fmts[i])] = 1'b0;
            bus.out_ready_i = 1'b0;
            drive(s, 1'b1);
            advance();
            idle();
            #1;
            g = observe();
            checks++; if (g.a !== exp_a[i]) begin failures++; $display("FAIL boxing_op0 fmt=%0d got=%h exp=%h", fmts[i], g.a, exp_a[i]); end
            checks++; if (g.b !== s.b) begin failures++; $display("FAIL boxing_op1 fmt=%0d got=%h exp=%h", fmts[i], g.b, s.b); end
            bus.out_ready_i = 1'b1;
            advance();
        end
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_fill();
        stim_t  s;
        entry_t g;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s     = rand_stim();
            s.tag = 1'(i);
            drive(s, 1'b1);
            #1;
            checks++; if (bus.in_ready_o !== (i < 3)) begin failures++; $display("FAIL fill_in_ready push=%0d got=%b exp=%b", i, bus.in_ready_o, (i < 3)); end
            advance();
        end
        idle();
        #1;
        checks++; if (bus.usage_o !== CW'(3)) begin failures++; $display("FAIL fill_usage got=%0d exp=3", bus.usage_o); end
        checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%b exp=0", bus.in_ready_o); end
        bus.out_ready_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            g = observe();
            checks++; if (bus.out_valid_o !== 1'b1 || g.tag !== 1'(j)) begin failures++; $display("FAIL fill_order idx=%0d got valid=%b tag=%b exp valid=1 tag=%b", j, bus.out_valid_o, g.tag, 1'(j)); end
            checks++; if (g !== mq[0]) begin failures++; $display("FAIL fill_entry idx=%0d got=%h exp=%h", j, g, mq[0]); end
            advance();
        end
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", bus.out_valid_o); end
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        int     tgt;
        entry_t g;
        for (int t = 0; t < 2; t++) begin
            tgt = (t == 0) ? 1 : int'(DEPTH) - 1;
            bus.out_ready_i = 1'b0;
            for (int i = 0; i < tgt; i++) begin
                drive(rand_stim(), 1'b1);
                advance();
            end
            for (int c = 0; c < 10; c++) begin
                drive(rand_stim(), 1'b1);
                bus.out_ready_i = 1'b1;
                #1;
                g = observe();
                checks++; if (bus.usage_o !== CW'(tgt)) begin failures++; $display("FAIL simul_usage cyc=%0d got=%0d exp=%0d", c, bus.usage_o, tgt); end
                checks++; if (g !== mq[0]) begin failures++; $display("FAIL simul_entry cyc=%0d got=%h exp=%h", c, g, mq[0]); end
                advance();
            end
            idle();
            for (int d = 0; d < int'(DEPTH) + 2; d++) advance();
            #1;
            checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL simul_drain got=%b exp=0", bus.busy_o); end
        end
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(rand_stim(), 1'b1);
            advance();
        end
        drive(rand_stim(), 1'b1);
        bus.flush_i = 1'b1;
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid_o); end
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready_o); end
        advance();
        idle();
        #1;
        checks++; if (bus.usage_o !== '0 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL flush_cleared got usage=%0d busy=%b exp usage=0 busy=0", bus.usage_o, bus.busy_o); end
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_not_stored got=%b exp=0", bus.out_valid_o); end
    endtask

    task automatic test_async_reset();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(rand_stim(), 1'b1);
            advance();
        end
        idle();
        #1;
        checks++; if (bus.usage_o !== CW'(DEPTH)) begin failures++; $display("FAIL areset_full got=%0d exp=%0d", bus.usage_o, DEPTH); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.usage_o !== '0)
            begin failures++; $display("FAIL areset_immediate got valid=%b ready=%b usage=%0d exp 0 1 0", bus.out_valid_o, bus.in_ready_o, bus.usage_o); end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        entry_t g;
        for (int c = 0; c < 400; c++) begin
            drive(rand_stim(), 1'($urandom_range(0, 1)));
            bus.out_ready_i = 1'($urandom_range(0, 1));
            bus.flush_i     = ($urandom_range(0, 19) == 0);
            #1;
            checks++; if (bus.in_ready_o !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready_o, (mq.size() != DEPTH)); end
            checks++; if (bus.out_valid_o !== (mq.size() != 0 && !bus.flush_i)) begin failures++; $display("FAIL rand_out_valid cyc=%0d got=%b", c, bus.out_valid_o); end
            checks++; if (bus.usage_o !== CW'(mq.size()) || bus.busy_o !== (mq.size() != 0)) begin failures++; $display("FAIL rand_usage cyc=%0d got=%0d exp=%0d", c, bus.usage_o, mq.size()); end
            if (mq.size() != 0) begin
                g = observe();
                checks++; if (g !== mq[0]) begin failures++; $display("FAIL rand_entry cyc=%0d got=%h exp=%h", c, g, mq[0]); end
            end
            advance();
        end
        idle();
        bus.out_ready_i = 1'b0;
    endtask

    initial begin
        bus.flush_i = 1'b0;
        test_reset();
        test_single_push();
        test_boxing();
        test_fill();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
